// File: rtl/imem_port_arb_if.sv
// Bundle between fetch stage, program loader and the imem array.
// The arbiter takes the slave side; requesters and memory take the master side.
interface imem_port_arb_if #(
    parameter int AW = 11
);
    logic          i_f_req;
    logic [31:0]   i_f_addr;
    logic          o_f_gnt;
    logic          o_f_rvalid;
    logic [31:0]   o_f_rdata;

    logic          i_l_req;
    logic          i_l_we;
    logic [31:0]   i_l_addr;
    logic [31:0]   i_l_wdata;
    logic          i_l_lock;
    logic          o_l_gnt;
    logic          o_l_rvalid;
    logic [31:0]   o_l_rdata;

    logic          o_load_mode;

    logic [AW-1:0] o_mem_addr;
    logic          o_mem_we;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   i_mem_rdata;

    modport slave (
        input  i_f_req, i_f_addr,
        input  i_l_req, i_l_we, i_l_addr, i_l_wdata, i_l_lock,
        input  i_mem_rdata,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        output o_l_gnt, o_l_rvalid, o_l_rdata,
        output o_load_mode,
        output o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport master (
        output i_f_req, i_f_addr,
        output i_l_req, i_l_we, i_l_addr, i_l_wdata, i_l_lock,
        output i_mem_rdata,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        input  o_l_gnt, o_l_rvalid, o_l_rdata,
        input  o_load_mode,
        input  o_mem_addr, o_mem_we, o_mem_wdata
    );
endinterface

// File: rtl/imem_port_arb.sv
// Fetch/loader arbiter for the single imem port (round robin, exclusive load mode).
// Optional IMEM_ARB_RANGE_CHECK_EN: out-of-range accesses skip memory and read as zero.
module imem_port_arb #(
    parameter int          AW       = 11,
    parameter logic [31:0] ADDR_MAX = 32'h1FFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    imem_port_arb_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_SHARE = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic SIDE_F = 1'b0;
    localparam logic SIDE_L = 1'b1;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic        owner_vld_q, owner_vld_d;
    logic        owner_id_q, owner_id_d;
    logic        owner_oor_q, owner_oor_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] l_rdata_q, l_rdata_d;

    logic        f_gnt;
    logic        l_gnt;
    logic        rd_gnt;
    logic [31:0] acc_addr;
    logic        acc_oor;
    logic        resp_vld;
    logic [31:0] resp_data;
    logic        f_rvalid;
    logic        l_rvalid;

    // Grant and next-state decision
    always_comb begin
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        state_d = state_q;
        rr_d    = rr_q;
        if (!i_rst) begin
            unique case (state_q)
                ST_SHARE: begin
                    if (bus.i_l_lock) begin
                        state_d = ST_LOAD;
                        l_gnt   = bus.i_l_req;
                    end else if (bus.i_f_req && bus.i_l_req) begin
                        f_gnt = (rr_q == SIDE_F);
                        l_gnt = (rr_q == SIDE_L);
                    end else begin
                        f_gnt = bus.i_f_req;
                        l_gnt = bus.i_l_req;
                    end
                    if (f_gnt) rr_d = SIDE_L;
                    if (l_gnt) rr_d = SIDE_F;
                end
                ST_LOAD: begin
                    l_gnt = bus.i_l_req;
                    if (!bus.i_l_lock) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    state_d = ST_SHARE;
                    rr_d    = SIDE_F;
                end
                default: begin
                    state_d = ST_SHARE;
                end
            endcase
        end
    end

    // Memory-side drive for the granted access
    always_comb begin
        acc_addr = l_gnt ? bus.i_l_addr : bus.i_f_addr;
`ifdef IMEM_ARB_RANGE_CHECK_EN
        acc_oor  = (acc_addr > ADDR_MAX);
`else
        acc_oor  = 1'b0;
`endif
        rd_gnt   = f_gnt || (l_gnt && !bus.i_l_we);

        bus.o_mem_addr  = '0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_wdata = '0;
        if ((f_gnt || l_gnt) && !acc_oor) begin
            bus.o_mem_addr = acc_addr[AW+1:2];
        end
        if (l_gnt && bus.i_l_we && !acc_oor) begin
            bus.o_mem_we    = 1'b1;
            bus.o_mem_wdata = bus.i_l_wdata;
        end

        owner_vld_d = rd_gnt;
        owner_id_d  = l_gnt ? SIDE_L : SIDE_F;
        owner_oor_d = rd_gnt && acc_oor;
    end

    // Response steering; rdata bypasses on the rvalid cycle, then holds
    always_comb begin
        resp_vld  = owner_vld_q && !i_rst;
        resp_data = owner_oor_q ? 32'h0000_0000 : bus.i_mem_rdata;
        f_rvalid  = resp_vld && (owner_id_q == SIDE_F);
        l_rvalid  = resp_vld && (owner_id_q == SIDE_L);
        f_rdata_d = f_rvalid ? resp_data : f_rdata_q;
        l_rdata_d = l_rvalid ? resp_data : l_rdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_SHARE;
            rr_q        <= SIDE_F;
            owner_vld_q <= 1'b0;
            owner_id_q  <= SIDE_F;
            owner_oor_q <= 1'b0;
            f_rdata_q   <= '0;
            l_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_vld_q <= owner_vld_d;
            owner_id_q  <= owner_id_d;
            owner_oor_q <= owner_oor_d;
            f_rdata_q   <= f_rdata_d;
            l_rdata_q   <= l_rdata_d;
        end
    end

    assign bus.o_f_gnt     = f_gnt;
    assign bus.o_l_gnt     = l_gnt;
    assign bus.o_f_rvalid  = f_rvalid;
    assign bus.o_l_rvalid  = l_rvalid;
    assign bus.o_f_rdata   = f_rdata_d;
    assign bus.o_l_rdata   = l_rdata_d;
    assign bus.o_load_mode = (state_q == ST_LOAD) && !i_rst;

    // Byte-offset bits and (without range check) high address bits are don't-care
    logic unused_bits;
    assign unused_bits = ^{bus.i_f_addr, bus.i_l_addr, ADDR_MAX};

endmodule

// File: tb/tb_imem_port_arb.sv
// Directed + random bench for imem_port_arb with a transaction-level reference model.
// Define IMEM_ARB_RANGE_CHECK_EN consistently for RTL and bench.
module tb_imem_port_arb;

    localparam int          AW    = 11;
    localparam int          WORDS = 2048;
    localparam logic [31:0] AMAX  = 32'h1FFF;
`ifdef IMEM_ARB_RANGE_CHECK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    imem_port_arb_if #(.AW(AW)) bus ();

    imem_port_arb #(.AW(AW), .ADDR_MAX(AMAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: synchronous-read imem array
    logic [31:0] mem_arr [WORDS];
    logic [31:0] mem_rd_q;
    always @(posedge clk) begin
        if (bus.o_mem_we) mem_arr[bus.o_mem_addr] <= bus.o_mem_wdata;
        mem_rd_q <= mem_arr[bus.o_mem_addr];
    end
    assign bus.i_mem_rdata = mem_rd_q;

    // Reference model state
    logic [31:0] ref_mem [WORDS];
    int          m_mode;
    bit          m_last_l;
    bit          p_vld;
    bit          p_l;
    logic [31:0] p_data;
    logic [31:0] h_f;
    logic [31:0] h_l;

    logic        obs_fg, obs_lg, obs_fv, obs_lv, obs_lm;
    logic [31:0] obs_fd, obs_ma;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit fq, input logic [31:0] fa,
                        input bit lq, input bit lw, input logic [31:0] la,
                        input logic [31:0] ld, input bit lk);
        bit          eg_f, eg_l, oor, ewe, ef_v, el_v;
        logic [31:0] a, word, ema, ewd, ef_d, el_d;
        rst           = r;
        bus.i_f_req   = fq;
        bus.i_f_addr  = fa;
        bus.i_l_req   = lq;
        bus.i_l_we    = lw;
        bus.i_l_addr  = la;
        bus.i_l_wdata = ld;
        bus.i_l_lock  = lk;

        eg_f = 1'b0;
        eg_l = 1'b0;
        if (!r) begin
            if (m_mode == 0) begin
                if (lk) eg_l = lq;
                else if (fq && lq) begin
                    eg_l = !m_last_l;
                    eg_f = m_last_l;
                end else begin
                    eg_f = fq;
                    eg_l = lq;
                end
            end else if (m_mode == 1) begin
                eg_l = lq;
            end
        end
        a    = eg_l ? la : fa;
        oor  = RCHK && (a > AMAX);
        word = (a >> 2) % WORDS;
        ema  = ((eg_f || eg_l) && !oor) ? word : 32'h0;
        ewe  = eg_l && lw && !oor;
        ewd  = ewe ? ld : 32'h0;
        ef_v = !r && p_vld && !p_l;
        el_v = !r && p_vld && p_l;
        ef_d = ef_v ? p_data : h_f;
        el_d = el_v ? p_data : h_l;

        @(negedge clk);
        obs_fg = bus.o_f_gnt;
        obs_lg = bus.o_l_gnt;
        obs_fv = bus.o_f_rvalid;
        obs_lv = bus.o_l_rvalid;
        obs_lm = bus.o_load_mode;
        obs_fd = bus.o_f_rdata;
        obs_ma = 32'(bus.o_mem_addr);
        chk("f_gnt", 32'(bus.o_f_gnt), 32'(eg_f));
        chk("l_gnt", 32'(bus.o_l_gnt), 32'(eg_l));
        chk("mem_we", 32'(bus.o_mem_we), 32'(ewe));
        chk("mem_addr", 32'(bus.o_mem_addr), ema);
        chk("mem_wdata", bus.o_mem_wdata, ewd);
        chk("load_mode", 32'(bus.o_load_mode), 32'(!r && m_mode == 1));
        chk("f_rvalid", 32'(bus.o_f_rvalid), 32'(ef_v));
        chk("l_rvalid", 32'(bus.o_l_rvalid), 32'(el_v));
        if (!r) begin
            chk("f_rdata", bus.o_f_rdata, ef_d);
            chk("l_rdata", bus.o_l_rdata, el_d);
        end

        if (r) begin
            m_mode   = 0;
            m_last_l = 1'b1;
            p_vld    = 1'b0;
            h_f      = 32'h0;
            h_l      = 32'h0;
        end else begin
            h_f    = ef_d;
            h_l    = el_d;
            p_vld  = eg_f || (eg_l && !lw);
            p_l    = eg_l;
            p_data = oor ? 32'h0 : ref_mem[word];
            if (ewe) ref_mem[word] = ld;
            if (m_mode == 0) begin
                if (eg_f) m_last_l = 1'b0;
                if (eg_l) m_last_l = 1'b1;
                if (lk) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!lk) m_mode = 2;
            end else begin
                m_mode   = 0;
                m_last_l = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit r);
        step(r, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        bit          lk, r, fq, lq, lw;
        logic [31:0] fa, la;
        checks = 0;
        errors = 0;
        for (int i = 0; i < WORDS; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        rst = 1'b1;
        bus.i_f_req = 1'b1;
        bus.i_l_req = 1'b1;
        bus.i_f_addr = '0;
        bus.i_l_addr = '0;
        bus.i_l_we = 1'b0;
        bus.i_l_wdata = '0;
        bus.i_l_lock = 1'b0;
        m_mode = 0;
        m_last_l = 1'b1;
        p_vld = 1'b0;
        p_l = 1'b0;
        p_data = '0;
        h_f = '0;
        h_l = '0;
        @(posedge clk);
        #1;

        // 1: reset with both requesting, then fetch first
        step(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        chk("t1_rst_fg", 32'(obs_fg), 32'h0);
        chk("t1_rst_lg", 32'(obs_lg), 32'h0);
        // 2: round robin F,L,F,L
        step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("t2_g0_f", 32'(obs_fg), 32'h1);
        step(1'b0, 1'b1, 32'h24, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
        chk("t2_g1_l", 32'(obs_lg), 32'h1);
        chk("t2_rv_f", 32'(obs_fv), 32'h1);
        step(1'b0, 1'b1, 32'h28, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0);
        chk("t2_g2_f", 32'(obs_fg), 32'h1);
        step(1'b0, 1'b1, 32'h2C, 1'b1, 1'b0, 32'h4C, 32'h0, 1'b0);
        chk("t2_g3_l", 32'(obs_lg), 32'h1);
        idle(1'b0);
        // 3: fetch streaming
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t3_a0", obs_ma, 32'h0);
        step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t3_a1", obs_ma, 32'h1);
        step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t3_a2", obs_ma, 32'h2);
        idle(1'b0);
        chk("t3_d2", obs_fd, ref_mem[2]);
        // 4: locked image load, drain, read back
        step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
        step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h14, 32'h1, 1'b1);
        chk("t4_mode", 32'(obs_lm), 32'h1);
        step(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h18, 32'h2, 1'b1);
        chk("t4_fg", 32'(obs_fg), 32'h0);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t4_drain", 32'(obs_fg | obs_lg), 32'h0);
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(1'b0);
        chk("t4_data", obs_fd, 32'hDEADBEEF);
        // 5: reset mid-read
        step(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(1'b1);
        chk("t5_rv", 32'(obs_fv), 32'h0);
        idle(1'b0);
        chk("t5_rv2", 32'(obs_fv), 32'h0);
        // 6: address above ADDR_MAX
        step(1'b0, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_addr", obs_ma, 32'h0);
        idle(1'b0);
        chk("t6_rv", 32'(obs_fv), 32'h1);
        chk("t6_data", obs_fd, RCHK ? 32'h0 : ref_mem[0]);

        // Randomized traffic
        lk = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) lk = !lk;
            fq = $urandom_range(0, 3) != 0;
            lq = $urandom_range(0, 2) != 0;
            lw = $urandom_range(0, 1) == 1;
            fa = {19'h0, 11'($urandom_range(0, 63)), 2'($urandom)};
            la = {19'h0, 11'($urandom_range(0, 63)), 2'($urandom)};
            if ($urandom_range(0, 15) == 0) fa = $urandom;
            if ($urandom_range(0, 15) == 0) la = 32'h2000 + 32'($urandom_range(0, 255));
            step(r, fq, fa, lq, lw, la, $urandom, lk);
        end
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
